// File: rtl/param_datapath_seq.sv
// Parametrised register-file datapath with a built-in three-step
// sequencer: T1 latches Y, T2 executes into Z, T3 writes back.
module param_datapath_seq #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rc,
   input  logic             ld_en,
   input  logic [AW-1:0]    ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] bus_out,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             flag_c,
   output logic             flag_z,
   output logic             err
);

   localparam int SW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      T1,
      T2,
      T3
   } state_t;

   state_t state, state_n;

   logic [WIDTH-1:0]   regs [NREGS];
   logic [WIDTH-1:0]   y;
   logic [WIDTH-1:0]   bus;
   logic [2*WIDTH-1:0] z;
   logic [2*WIDTH-1:0] alu_z;
   logic [WIDTH:0]     sum;
   logic [3:0]         op_q;
   logic [AW-1:0]      ra_q, rb_q, rc_q;
   logic               alu_c, alu_cwe, op_ok;

   assign rd_data = regs[rd_addr];
   assign bus_out = bus;

   always_comb begin
      bus = '0;
      unique case (state)
         T1:      bus = regs[rb_q];
         T2:      bus = regs[rc_q];
         T3:      bus = z[WIDTH-1:0];
         default: bus = '0;
      endcase
   end

   always_comb begin
      alu_z   = '0;
      alu_c   = 1'b0;
      alu_cwe = 1'b0;
      op_ok   = 1'b1;
      sum     = {1'b0, y} + {1'b0, bus};
      case (op_q)
         4'd0: begin
            alu_z[WIDTH-1:0] = sum[WIDTH-1:0];
            alu_c            = sum[WIDTH];
            alu_cwe          = 1'b1;
         end
         4'd1: begin
            alu_z[WIDTH-1:0] = y - bus;
            alu_c            = (y >= bus);
            alu_cwe          = 1'b1;
         end
         4'd2: alu_z[WIDTH-1:0] = y & bus;
         4'd3: alu_z[WIDTH-1:0] = y | bus;
         4'd4: alu_z[WIDTH-1:0] = y ^ bus;
         4'd5: alu_z[WIDTH-1:0] = y << bus[SW-1:0];
         4'd6: alu_z[WIDTH-1:0] = y >> bus[SW-1:0];
         4'd7: alu_z[WIDTH-1:0] = ~bus;
         4'd8: alu_z = {{WIDTH{1'b0}}, y}
                     * {{WIDTH{1'b0}}, bus};
         default: op_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start) state_n = T1;
         T1:      state_n = T2;
         T2:      state_n = T3;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         y      <= '0;
         z      <= '0;
         hi     <= '0;
         lo     <= '0;
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         err    <= 1'b0;
         done   <= 1'b0;
         busy   <= 1'b0;
         op_q   <= '0;
         ra_q   <= '0;
         rb_q   <= '0;
         rc_q   <= '0;
      end else begin
         busy <= (state_n != IDLE);
         done <= (state == T3);
         err  <= (state == T3) && !op_ok;
         unique case (state)
            IDLE: begin
               // load and start may share an edge; T1 then sees the new value
               if (ld_en) regs[ld_addr] <= ld_data;
               if (start) begin
                  op_q <= op;
                  ra_q <= ra;
                  rb_q <= rb;
                  rc_q <= rc;
               end
            end
            T1: y <= bus;
            T2: begin
               z <= alu_z;
               if (alu_cwe) flag_c <= alu_c;
            end
            default: begin
               if (op_ok) begin
                  regs[ra_q] <= z[WIDTH-1:0];
                  flag_z     <= (z[WIDTH-1:0] == '0);
                  if (op_q == 4'd8) begin
                     hi <= z[2*WIDTH-1:WIDTH];
                     lo <= z[WIDTH-1:0];
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_datapath_seq.sv
// Scoreboard bench for param_datapath_seq: expectations are queued
// at issue time and compared when done pulses.
module tb_param_datapath_seq;

   localparam int W = 32;
   localparam int N = 16;
   localparam int A = 4;

   logic         clock = 1'b0;
   logic         clear = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   op = '0;
   logic [A-1:0] ra = '0, rb = '0, rc = '0;
   logic         ld_en = 1'b0;
   logic [A-1:0] ld_addr = '0, rd_addr = '0;
   logic [W-1:0] ld_data = '0;
   logic [W-1:0] rd_data, bus_out, hi, lo;
   logic         busy, done, flag_c, flag_z, err;

   int pass_n = 0;
   int total_n = 0;

   logic [W-1:0] m [N];
   logic         m_fc = 1'b0, m_fz = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0;

   typedef struct {
      logic [A-1:0] ra;
      logic [W-1:0] val;
      logic         fc;
      logic         fz;
      logic         err;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t sbq[$];

   param_datapath_seq #(.WIDTH(W), .NREGS(N)) dut (
      .clock(clock), .clear(clear), .start(start), .op(op),
      .ra(ra), .rb(rb), .rc(rc), .ld_en(ld_en),
      .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
      .rd_data(rd_data), .bus_out(bus_out), .hi(hi), .lo(lo),
      .busy(busy), .done(done), .flag_c(flag_c),
      .flag_z(flag_z), .err(err)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      foreach (m[i]) m[i] = '0;
      m_fc = 1'b0;
      m_fz = 1'b0;
      m_hi = '0;
      m_lo = '0;
      sbq.delete();
   endtask

   function automatic void model(
      input  logic [3:0]   o,
      input  logic [W-1:0] a,
      input  logic [W-1:0] b,
      output logic [63:0]  zf,
      output logic         cw,
      output logic         c
   );
      longint unsigned la, lb;
      logic [W-1:0] t;
      la = 64'(a);
      lb = 64'(b);
      zf = '0;
      cw = 1'b0;
      c  = 1'b0;
      t  = '0;
      case (o)
         4'd0: begin
            zf = la + lb;
            c  = zf[32];
            zf[63:32] = '0;
            cw = 1'b1;
         end
         4'd1: begin
            t  = a - b;
            zf = {32'h0, t};
            c  = !(la < lb);
            cw = 1'b1;
         end
         4'd2: zf = {32'h0, a & b};
         4'd3: zf = {32'h0, a | b};
         4'd4: zf = {32'h0, a ^ b};
         4'd5: begin t = a << b[4:0]; zf = {32'h0, t}; end
         4'd6: begin t = a >> b[4:0]; zf = {32'h0, t}; end
         4'd7: zf = {32'h0, ~b};
         4'd8: zf = la * lb;
         default: zf = '0;
      endcase
   endfunction

   task automatic push_exp(
      input logic [3:0] o,
      input logic [A-1:0] d,
      input logic [A-1:0] s1,
      input logic [A-1:0] s2
   );
      exp_t e;
      logic [63:0] zf;
      logic cw, c;
      model(o, m[s1], m[s2], zf, cw, c);
      e.ra  = d;
      e.err = (o > 4'd8);
      if (!e.err) begin
         m[d] = zf[31:0];
         if (cw) m_fc = c;
         m_fz = (zf[31:0] == 32'h0);
         if (o == 4'd8) begin
            m_hi = zf[63:32];
            m_lo = zf[31:0];
         end
      end
      e.val = m[d];
      e.fc  = m_fc;
      e.fz  = m_fz;
      e.hi  = m_hi;
      e.lo  = m_lo;
      sbq.push_back(e);
   endtask

   task automatic load(input logic [A-1:0] a, input logic [W-1:0] d);
      ld_en = 1'b1;
      ld_addr = a;
      ld_data = d;
      tick();
      ld_en = 1'b0;
      m[a] = d;
   endtask

   task automatic issue(
      input logic [3:0] o,
      input logic [A-1:0] d,
      input logic [A-1:0] s1,
      input logic [A-1:0] s2
   );
      push_exp(o, d, s1, s2);
      op = o;
      ra = d;
      rb = s1;
      rc = s2;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(
      input  int e0,
      output int edges,
      output int nb,
      output bit to
   );
      edges = e0;
      nb = 0;
      while (done !== 1'b1 && edges < 12) begin
         if (busy === 1'b1) nb++;
         tick();
         edges++;
      end
      to = (done !== 1'b1);
   endtask

   task automatic test_reset();
      clear = 1'b0;
      tick();
      tick();
      total_n++;
      if ({busy, done, err, flag_c, flag_z} !== 5'b0)
         $display("FAIL rst_ctl got %b exp 00000",
                  {busy, done, err, flag_c, flag_z});
      else pass_n++;
      total_n++;
      if ({hi, lo, bus_out} !== '0)
         $display("FAIL rst_data got %h %h %h exp 0", hi, lo, bus_out);
      else pass_n++;
      for (int i = 0; i < N; i++) begin
         rd_addr = A'(i);
         #1;
         total_n++;
         if (rd_data !== '0)
            $display("FAIL rst_r%0d got %h exp 0", i, rd_data);
         else pass_n++;
      end
      clear = 1'b1;
      model_reset();
      tick();
   endtask

   task automatic test_add_carry();
      int ed, nb;
      bit to;
      exp_t e;
      load(4'd1, 32'hFFFF_FFFF);
      load(4'd2, 32'h1);
      issue(4'd0, 4'd3, 4'd1, 4'd2);
      wait_done(1, ed, nb, to);
      total_n++;
      if (to || ed != 4)
         $display("FAIL add_latency got %0d exp 4", ed);
      else pass_n++;
      total_n++;
      if (nb != 3 || busy !== 1'b0)
         $display("FAIL add_busy got %0d/%b exp 3/0", nb, busy);
      else pass_n++;
      e = sbq.pop_front();
      rd_addr = e.ra;
      #1;
      total_n++;
      if (rd_data !== e.val || err !== e.err)
         $display("FAIL add_res got %h/%b exp %h/%b",
                  rd_data, err, e.val, e.err);
      else pass_n++;
      total_n++;
      if ({flag_c, flag_z} !== {e.fc, e.fz})
         $display("FAIL add_flags got %b%b exp %b%b",
                  flag_c, flag_z, e.fc, e.fz);
      else pass_n++;
   endtask

   task automatic test_sub_same();
      int ed, nb;
      bit to;
      exp_t e;
      load(4'd4, 32'd3);
      load(4'd5, 32'd10);
      issue(4'd1, 4'd4, 4'd4, 4'd5);
      wait_done(1, ed, nb, to);
      total_n++;
      if (to) $display("FAIL sub_timeout got 0 exp 1");
      else pass_n++;
      e = sbq.pop_front();
      rd_addr = e.ra;
      #1;
      total_n++;
      if (rd_data !== e.val || rd_data !== 32'hFFFF_FFF9)
         $display("FAIL sub_res got %h exp %h", rd_data, e.val);
      else pass_n++;
      total_n++;
      if ({flag_c, flag_z, err} !== {e.fc, e.fz, e.err})
         $display("FAIL sub_flags got %b%b%b exp %b%b%b",
                  flag_c, flag_z, err, e.fc, e.fz, e.err);
      else pass_n++;
   endtask

   task automatic test_mul();
      int ed, nb;
      bit to;
      exp_t e;
      load(4'd1, 32'h0001_0000);
      load(4'd2, 32'h0003_0000);
      issue(4'd8, 4'd6, 4'd1, 4'd2);
      wait_done(1, ed, nb, to);
      total_n++;
      if (to) $display("FAIL mul_timeout got 0 exp 1");
      else pass_n++;
      e = sbq.pop_front();
      rd_addr = e.ra;
      #1;
      total_n++;
      if (hi !== e.hi || lo !== e.lo || hi !== 32'h3)
         $display("FAIL mul_hilo got %h/%h exp %h/%h",
                  hi, lo, e.hi, e.lo);
      else pass_n++;
      total_n++;
      if (rd_data !== e.val || flag_z !== e.fz || flag_c !== e.fc)
         $display("FAIL mul_res got %h/%b%b exp %h/%b%b",
                  rd_data, flag_c, flag_z, e.val, e.fc, e.fz);
      else pass_n++;
   endtask

   task automatic test_back_to_back();
      int ed, nb;
      bit to;
      exp_t e;
      load(4'd7, 32'h0000_1234);
      load(4'd8, 32'h0000_00FF);
      issue(4'd2, 4'd9, 4'd7, 4'd8);
      wait_done(1, ed, nb, to);
      e = sbq.pop_front();
      rd_addr = e.ra;
      #1;
      total_n++;
      if (to || rd_data !== e.val || err !== e.err)
         $display("FAIL b2b_first got %h exp %h", rd_data, e.val);
      else pass_n++;
      issue(4'd4, 4'd10, 4'd7, 4'd8);
      ld_en = 1'b1;
      ld_addr = 4'd7;
      ld_data = 32'hDEAD_BEEF;
      tick();
      ld_en = 1'b0;
      wait_done(2, ed, nb, to);
      total_n++;
      if (to || ed != 4)
         $display("FAIL b2b_latency got %0d exp 4", ed);
      else pass_n++;
      e = sbq.pop_front();
      rd_addr = e.ra;
      #1;
      total_n++;
      if (rd_data !== e.val || flag_c !== e.fc || flag_z !== e.fz)
         $display("FAIL b2b_second got %h exp %h", rd_data, e.val);
      else pass_n++;
      rd_addr = 4'd7;
      #1;
      total_n++;
      if (rd_data !== m[7])
         $display("FAIL busy_ld got %h exp %h", rd_data, m[7]);
      else pass_n++;
      tick();
      ld_en = 1'b1;
      ld_addr = 4'd11;
      ld_data = 32'h55;
      m[11] = 32'h55;
      issue(4'd0, 4'd12, 4'd11, 4'd11);
      ld_en = 1'b0;
      wait_done(1, ed, nb, to);
      e = sbq.pop_front();
      rd_addr = e.ra;
      #1;
      total_n++;
      if (to || rd_data !== e.val || rd_data !== 32'hAA)
         $display("FAIL ld_start got %h exp %h", rd_data, e.val);
      else pass_n++;
   endtask

   task automatic test_invalid();
      int ed, nb, extra;
      bit to;
      exp_t e;
      tick();
      issue(4'd12, 4'd1, 4'd7, 4'd8);
      start = 1'b1;
      op = 4'd0;
      ra = 4'd2;
      tick();
      tick();
      start = 1'b0;
      wait_done(3, ed, nb, to);
      total_n++;
      if (to || ed != 4 || err !== 1'b1)
         $display("FAIL inv_err got %b/%0d exp 1/4", err, ed);
      else pass_n++;
      e = sbq.pop_front();
      rd_addr = e.ra;
      #1;
      total_n++;
      if (rd_data !== e.val || {flag_c, flag_z} !== {e.fc, e.fz})
         $display("FAIL inv_nochange got %h exp %h", rd_data, e.val);
      else pass_n++;
      extra = 0;
      repeat (3) begin
         tick();
         if (busy !== 1'b0 || done !== 1'b0) extra++;
      end
      rd_addr = 4'd2;
      #1;
      total_n++;
      if (extra != 0 || rd_data !== m[2])
         $display("FAIL inv_extra got %0d/%h exp 0/%h",
                  extra, rd_data, m[2]);
      else pass_n++;
   endtask

   task automatic test_random();
      int ed, nb;
      bit to;
      exp_t e;
      logic [3:0] o;
      for (int i = 0; i < 4; i++) load(A'(i), $urandom);
      for (int k = 0; k < 12; k++) begin
         o = 4'($urandom_range(0, 8));
         issue(o, A'($urandom_range(0, N - 1)),
               A'($urandom_range(0, 3)), A'($urandom_range(0, 3)));
         wait_done(1, ed, nb, to);
         e = sbq.pop_front();
         rd_addr = e.ra;
         #1;
         total_n++;
         if (to || rd_data !== e.val || hi !== e.hi || lo !== e.lo ||
             {flag_c, flag_z, err} !== {e.fc, e.fz, e.err})
            $display("FAIL rnd_op%0d got %h %b%b exp %h %b%b", o,
                     rd_data, flag_c, flag_z, e.val, e.fc, e.fz);
         else pass_n++;
         tick();
      end
   endtask

   task automatic test_reset_mid_op();
      int ed, nb;
      bit to;
      exp_t e;
      load(4'd1, 32'd5);
      load(4'd2, 32'd7);
      issue(4'd0, 4'd3, 4'd1, 4'd2);
      tick();
      clear = 1'b0;
      #1;
      total_n++;
      if ({busy, done, err, flag_c, flag_z} !== 5'b0 ||
          {hi, lo, bus_out} !== '0)
         $display("FAIL mid_rst_out got %b %h exp 0",
                  {busy, done, err, flag_c, flag_z}, bus_out);
      else pass_n++;
      rd_addr = 4'd3;
      #1;
      total_n++;
      if (rd_data !== '0)
         $display("FAIL mid_rst_r3 got %h exp 0", rd_data);
      else pass_n++;
      model_reset();
      tick();
      clear = 1'b1;
      tick();
      load(4'd1, 32'd5);
      load(4'd2, 32'd7);
      issue(4'd0, 4'd3, 4'd1, 4'd2);
      wait_done(1, ed, nb, to);
      e = sbq.pop_front();
      rd_addr = e.ra;
      #1;
      total_n++;
      if (to || rd_data !== e.val || rd_data !== 32'd12)
         $display("FAIL mid_rst_add got %h exp %h", rd_data, e.val);
      else pass_n++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_add_carry();
      test_sub_same();
      test_mul();
      test_back_to_back();
      test_invalid();
      test_random();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
